// File: rtl/misc_v_ex_pkg.sv
// Shared definitions for the MISC-V execute stage.
//   - ALU operation codes carried on IALUOp
//   - forwarding mux select codes for operands 1/2 and for the store operand
//   - state type of the iterative multiplier
package misc_v_ex_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] FWD_MEM  = 2'd0;
  localparam logic [1:0] FWD_WB   = 2'd1;
  localparam logic [1:0] FWD_REG  = 2'd2;
  localparam logic [1:0] FWD_ZERO = 2'd3;

  localparam logic FWD3_WB  = 1'b0;
  localparam logic FWD3_REG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_start       : accepted in IDLE only; latches i_a/i_b and begins
//   i_flush       : abandons any operation, back to IDLE with acc cleared
//   i_hold        : keeps the result presented in DONE
//   i_a, i_b      : operands
//   o_busy        : iterating (BUSY)
//   o_done        : result valid on o_product (DONE)
//   o_product     : low DATA_W bits of i_a * i_b
module seq_multiplier
  import misc_v_ex_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mul_state_t        r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_b[0]) begin
            r_acc <= r_acc + r_a;
          end
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!i_hold) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == BUSY);
  assign o_done    = (r_state == DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/execute_stage_mc.sv
// MISC-V execute stage: ID/EX register, operand forwarding, single-cycle
// ALU and an iterative multiplier that stalls the front of the pipeline.
//   clk, reset            : clock, asynchronous active-low reset
//   IValid, I*            : decode slot contents (control, data, indices)
//   ALUResultMEM/loadDataWB: forwarding sources
//   muxFwd1/2select       : 0 MEM, 1 WB, 2 ID/EX operand, 3 zero
//   muxFwd3select         : 0 WB, 1 ID/EX operand
//   stall_i / flush_i     : downstream hold / squash instruction in EX
//   O*                    : to EX/MEM register (bubble while ex_stall_o)
//   ex_stall_o            : upstream must hold IF/ID and decode
module execute_stage_mc
  import misc_v_ex_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IValid,
  input  logic              IRegWrite,
  input  logic              IALUSrc,
  input  logic              IMemWrite,
  input  logic              IMemRead,
  input  logic [2:0]        IALUOp,
  input  logic [1:0]        IRegStore,
  input  logic [DATA_W-1:0] IPCP2,
  input  logic [DATA_W-1:0] I1stArg,
  input  logic [DATA_W-1:0] I2ndArg,
  input  logic [DATA_W-1:0] I3rdArg,
  input  logic [DATA_W-1:0] Imm,
  input  logic [REG_W-1:0]  IRs1,
  input  logic [REG_W-1:0]  IRs2,
  input  logic [REG_W-1:0]  IRd,
  input  logic [DATA_W-1:0] ALUResultMEM,
  input  logic [DATA_W-1:0] loadDataWB,
  input  logic [1:0]        muxFwd1select,
  input  logic [1:0]        muxFwd2select,
  input  logic              muxFwd3select,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              OValid,
  output logic              ORegWrite,
  output logic              OMemWrite,
  output logic              OMemRead,
  output logic [1:0]        ORegStore,
  output logic [DATA_W-1:0] OPCP2,
  output logic [DATA_W-1:0] OALUResult,
  output logic [DATA_W-1:0] O3rdArg,
  output logic [REG_W-1:0]  ORs1,
  output logic [REG_W-1:0]  ORs2,
  output logic [REG_W-1:0]  ORd,
  output logic              ex_stall_o
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  if (DATA_W < 4 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_width
    $error("execute_stage_mc: DATA_W must be a power of two and at least 4");
  end

  // ID/EX register
  logic              r_valid;
  logic              r_regwrite;
  logic              r_alusrc;
  logic              r_memwrite;
  logic              r_memread;
  logic [2:0]        r_aluop;
  logic [1:0]        r_regstore;
  logic [DATA_W-1:0] r_pcp2;
  logic [DATA_W-1:0] r_arg1;
  logic [DATA_W-1:0] r_arg2;
  logic [DATA_W-1:0] r_arg3;
  logic [DATA_W-1:0] r_imm;
  logic [REG_W-1:0]  r_rs1;
  logic [REG_W-1:0]  r_rs2;
  logic [REG_W-1:0]  r_rd;

  logic              w_hold;
  logic [DATA_W-1:0] w_alu_in1;
  logic [DATA_W-1:0] w_fwd2;
  logic [DATA_W-1:0] w_alu_in2;
  logic [DATA_W-1:0] w_fwd3;
  logic [SH_W-1:0]   w_shamt;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_product;

  assign w_hold = ex_stall_o | stall_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_memwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_aluop    <= '0;
      r_regstore <= '0;
      r_pcp2     <= '0;
      r_arg1     <= '0;
      r_arg2     <= '0;
      r_arg3     <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (flush_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_memwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_aluop    <= '0;
      r_regstore <= '0;
      r_pcp2     <= '0;
      r_arg1     <= '0;
      r_arg2     <= '0;
      r_arg3     <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (!w_hold) begin
      r_valid    <= IValid;
      r_regwrite <= IRegWrite;
      r_alusrc   <= IALUSrc;
      r_memwrite <= IMemWrite;
      r_memread  <= IMemRead;
      r_aluop    <= IALUOp;
      r_regstore <= IRegStore;
      r_pcp2     <= IPCP2;
      r_arg1     <= I1stArg;
      r_arg2     <= I2ndArg;
      r_arg3     <= I3rdArg;
      r_imm      <= Imm;
      r_rs1      <= IRs1;
      r_rs2      <= IRs2;
      r_rd       <= IRd;
    end
  end

  // Forwarding muxes
  always_comb begin
    w_alu_in1 = '0;
    case (muxFwd1select)
      FWD_MEM: w_alu_in1 = ALUResultMEM;
      FWD_WB:  w_alu_in1 = loadDataWB;
      FWD_REG: w_alu_in1 = r_arg1;
      default: w_alu_in1 = '0;
    endcase
  end

  always_comb begin
    w_fwd2 = '0;
    case (muxFwd2select)
      FWD_MEM: w_fwd2 = ALUResultMEM;
      FWD_WB:  w_fwd2 = loadDataWB;
      FWD_REG: w_fwd2 = r_arg2;
      default: w_fwd2 = '0;
    endcase
  end

  assign w_alu_in2 = r_alusrc ? r_imm : w_fwd2;
  assign w_fwd3    = (muxFwd3select == FWD3_REG) ? r_arg3 : loadDataWB;
  assign w_shamt   = w_alu_in2[SH_W-1:0];

  // Multiplier: start is gated by flush so a squashed MUL never launches.
  assign w_mul_start = MUL_EN && r_valid && (r_aluop == OP_MUL) && !flush_i;

  seq_multiplier #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (reset),
    .i_start   (w_mul_start),
    .i_flush   (flush_i),
    .i_hold    (stall_i),
    .i_a       (w_alu_in1),
    .i_b       (w_alu_in2),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // Stall covers the launch cycle in IDLE as well as all BUSY cycles.
  assign ex_stall_o = (w_mul_start && !w_mul_busy && !w_mul_done) || w_mul_busy;

  always_comb begin
    w_alu_res = '0;
    case (r_aluop)
      OP_ADD:  w_alu_res = w_alu_in1 + w_alu_in2;
      OP_SUB:  w_alu_res = w_alu_in1 - w_alu_in2;
      OP_AND:  w_alu_res = w_alu_in1 & w_alu_in2;
      OP_OR:   w_alu_res = w_alu_in1 | w_alu_in2;
      OP_XOR:  w_alu_res = w_alu_in1 ^ w_alu_in2;
      OP_SLL:  w_alu_res = w_alu_in1 << w_shamt;
      OP_SRL:  w_alu_res = w_alu_in1 >> w_shamt;
      OP_MUL:  w_alu_res = (MUL_EN && w_mul_done) ? w_mul_product : '0;
      default: w_alu_res = '0;
    endcase
  end

  // Outputs: forced to zero while reset is asserted, since the forwarding
  // muxes would otherwise pass live bypass data straight through.
  always_comb begin
    OValid     = 1'b0;
    ORegWrite  = 1'b0;
    OMemWrite  = 1'b0;
    OMemRead   = 1'b0;
    ORegStore  = '0;
    OPCP2      = '0;
    OALUResult = '0;
    O3rdArg    = '0;
    ORs1       = '0;
    ORs2       = '0;
    ORd        = '0;
    if (reset) begin
      OValid     = r_valid    & ~ex_stall_o;
      ORegWrite  = r_regwrite & ~ex_stall_o;
      OMemWrite  = r_memwrite & ~ex_stall_o;
      OMemRead   = r_memread  & ~ex_stall_o;
      ORegStore  = r_regstore;
      OPCP2      = r_pcp2;
      OALUResult = w_alu_res;
      O3rdArg    = w_fwd3;
      ORs1       = r_rs1;
      ORs2       = r_rs2;
      ORd        = r_rd;
    end
  end

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
- Parametrised next-generation execute stage for the MISC-V pipeline, sitting between decode and the EX/MEM register.
- Contains the ID/EX pipeline register, the operand forwarding muxes, a single-cycle ALU, and a new iterative shift-add multiplier.
- The multiplier takes several cycles, so the block generates its own pipeline stall and honours external stall and flush requests.

Parameters:
- DATA_W, 16, datapath width; must be ≥4 and a power of two.
- REG_W, 3, register-index width.
- MUL_EN, 1, enables the multiplier; when 0, op MUL is single-cycle and yields 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- IValid  in  1  decode slot holds a real instruction
- IRegWrite, IALUSrc, IMemWrite, IMemRead  in  1 each  decode control
- IALUOp  in  3  operation code (see Behaviour)
- IRegStore  in  2  writeback source select, passed through
- IPCP2, I1stArg, I2ndArg, I3rdArg, Imm  in  DATA_W each  decode data
- IRs1, IRs2, IRd  in  REG_W each  register indices
- ALUResultMEM, loadDataWB  in  DATA_W  forwarding sources
- muxFwd1select, muxFwd2select  in  2  0=MEM, 1=WB, 2=ID/EX reg, 3=zero
- muxFwd3select  in  1  0=WB, 1=ID/EX reg
- stall_i  in  1  downstream hold
- flush_i  in  1  squash the instruction in EX
- OValid, ORegWrite, OMemWrite, OMemRead  out  1  to EX/MEM
- ORegStore  out  2
- OPCP2, OALUResult, O3rdArg  out  DATA_W
- ORs1, ORs2, ORd  out  REG_W
- ex_stall_o  out  1  upstream must hold IF/ID and decode

Behaviour:
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
- ADD, SUB and MUL wrap modulo 2^DATA_W (MUL returns the low DATA_W bits).
- Shift amount is ALUIn2[$clog2(DATA_W)-1:0]; SRL is a logical shift.
- Datapath:
  - ALUIn1 = fwd1 mux output.
  - ALUIn2 = Imm when ALUSrc=1, else fwd2 mux output.
  - O3rdArg = fwd3 mux output.
  - Single-cycle ops: OALUResult is combinational from the ID/EX register plus forwarding, giving 0 added latency.
- ID/EX register control priority is reset > flush_i > hold > load:
  - Hold condition: ex_stall_o | stall_i.
  - Flush: clears valid and all control bits; data fields don't-care, implemented as cleared to 0.
- Multiplier FSM (state in shared package):
  - IDLE:
    - If registered valid & op==MUL & MUL_EN, latch A=ALUIn1, B=ALUIn2, acc=0, cnt=0; ex_stall_o=1; next state BUSY.
    - Otherwise ex_stall_o=0.
  - BUSY:
    - Each cycle: if B[0], acc+=A; then A<<=1, B>>=1, cnt++.
    - Leave for DONE when cnt==DATA_W-1 (DATA_W BUSY cycles).
    - ex_stall_o=1.
  - DONE: OALUResult=acc; ex_stall_o=0. Go to IDLE when stall_i=0; stay in DONE while stall_i=1.
  - A MUL therefore occupies EX for DATA_W+2 cycles, with ex_stall_o high for DATA_W+1 of them.
  - Operands are latched in IDLE, so later changes on forwarding sources or selects do not affect the result.
- While ex_stall_o=1, outputs form a bubble: OValid, ORegWrite, OMemWrite and OMemRead are forced to 0. Other outputs are don't-care.
- stall_i=1:
  - ID/EX holds and outputs stay stable.
  - FSM keeps iterating in BUSY.
  - stall_i does not itself raise ex_stall_o.
- flush_i=1 in any state: FSM goes to IDLE next cycle, acc cleared, ID/EX squashed, ex_stall_o drops next cycle.
- reset low, at any time including mid-MUL: immediately FSM=IDLE, cnt/acc/A/B=0, ID/EX cleared. All outputs read 0, and ex_stall_o=0.
- Back-to-back MULs: the second enters ID/EX in the cycle after DONE and restarts from IDLE.
- MUL_EN=0: op 7 gives OALUResult=0 in a single cycle; the FSM is never entered.

Decomposition:
- Package misc_v_ex_pkg holds:
  - ALU op-code constants.
  - Forwarding select codes (FWD_MEM, FWD_WB, FWD_REG, FWD_ZERO).
  - Multiplier state enum (IDLE, BUSY, DONE).
- One sub-module, seq_multiplier, parametrised by DATA_W. It owns the FSM, cnt, A, B and acc. Interface: start, flush, operands, busy, done, product.
- The ID/EX register, muxes and single-cycle ALU stay in the top level.

Test Plan:
- ADD, fwd1=MEM (ALUResultMEM=0x0010), reg arg2=0x0005, ALUSrc=0 -> OALUResult=0x0015 in the same cycle, OValid=1.
- SUB 0x0000-0x0001 -> 0xFFFF. SLL 0x0001 by Imm=0x0013, ALUSrc=1 -> 0x0008 (amount 3 after masking).
- MUL 7*9, DATA_W=16 -> ex_stall_o high for 17 cycles, outputs are bubbles, then OALUResult=0x003F with OValid=1 for one cycle.
- MUL 0x0100*0x0100 -> 0x0000, showing wrap.
- MUL with fwd1=WB (loadDataWB=3) and arg2=4, loadDataWB changed to 99 on the next cycle -> result still 12.
- flush_i at BUSY cycle 5 -> next cycle ex_stall_o=0, OValid=0, FSM IDLE. Following ADD 1+1 -> 2 with no leftover accumulator.
- reset low mid-BUSY -> all outputs 0 immediately, not waiting for clk. After release, a MUL 2*3 -> 6 with correct timing.
- stall_i held 3 cycles in DONE -> OALUResult=acc stable, FSM stays DONE, then advances to IDLE.
